// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an RV32M issue stage and the iterative multiply/divide unit.
// The master drives the operation request; the slave returns status, the result and the register-file write.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            write_enable;

    modport master (
        output start, flush, funct3, rs1_val, rs2_val, rd,
        input  busy, done, result, rd_out, write_enable
    );

    modport slave (
        input  start, flush, funct3, rs1_val, rs2_val, rd,
        output busy, done, result, rd_out, write_enable
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle over magnitudes, signs fixed up at the end.
// Divide-by-zero and signed overflow skip the iteration and finish one edge after being accepted.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'(XLEN - 1);

    state_t          state;
    state_t          state_next;
    logic [4:0]      count;
    logic [2:0]      op;
    logic [4:0]      rd_hold;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] operand;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;

    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;

    // Request decode works straight off the bus so special cases can complete on the accepting edge.
    assign is_div   = bus.funct3[2];
    assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
    assign a_neg    = a_signed && bus.rs1_val[XLEN-1];
    assign b_neg    = b_signed && bus.rs2_val[XLEN-1];
    assign mag_a    = a_neg ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
    assign mag_b    = b_neg ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
    assign div_zero = is_div && (bus.rs2_val == '0);
    assign div_ovf  = is_div && !bus.funct3[0] &&
                      (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
    assign special  = div_zero || div_ovf;
    assign special_result = div_zero ? (bus.funct3[1] ? bus.rs1_val : '1)
                                     : (bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;

    // acc_hi holds the partial product / running remainder, acc_lo the multiplier / quotient bits.
    always_comb begin
        step_hi   = '0;
        step_lo   = '0;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (op[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] signed_product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   final_result;

    assign product        = {step_hi, step_lo};
    assign signed_product = neg_q ? (~product + 1'b1) : product;
    assign quotient       = neg_q ? (~step_lo + 1'b1) : step_lo;
    assign remainder      = neg_r ? (~step_hi + 1'b1) : step_hi;
    assign final_result   = op[2] ? (op[1] ? remainder : quotient)
                                  : ((op[1:0] == 2'b00) ? signed_product[XLEN-1:0]
                                                        : signed_product[2*XLEN-1:XLEN]);

    // State register of the IDLE/CALC/DONE controller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides everything, including a start presented in the same cycle.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = special ? DONE : CALC;
                CALC:    if (count == LAST_STEP) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The visible result and rd_out only move on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            op       <= '0;
            rd_hold  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op      <= bus.funct3;
                        rd_hold <= bus.rd;
                        count   <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= is_div ? mag_a : mag_b;
                        operand <= is_div ? mag_b : mag_a;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        if (special) begin
                            result_q <= special_result;
                            rd_out_q <= bus.rd;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 5'd1;
                    if (count == LAST_STEP) begin
                        result_q <= final_result;
                        rd_out_q <= rd_hold;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
    assign bus.write_enable = (state == DONE) && (rd_out_q != 5'd0);
endmodule
